load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit placed between the pipeline's MEM stage and `DATA_MEMORY`. It converts RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-indexed `DATA_MEMORY` accesses. Sub-word stores are performed as a two-cycle read-modify-write that stalls the pipeline. The block also sign/zero-extends load data, and detects misaligned, illegal and segmentation faults, latching the first faulting address.

## Interface
Parameters:
- None.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `REQ_ADDRESS`  in  32  byte address from the ALU.
- `REQ_FUNCT3`  in  3  RV32I load/store funct3.
- `REQ_MemRead`  in  1  load request.
- `REQ_MemWrite`  in  1  store request.
- `REQ_WRITE_DATA`  in  32  store source register value (rs2).
- `STALL`  out  1  pipeline must hold all REQ_* inputs stable while high.
- `LOAD_DATA`  out  32  extended load result. Valid in the cycle `REQ_MemRead`=1 and `STALL`=0.
- `ACCESS_FAULT`  out  1  current request faulted (combinational).
- `FAULT_LATCHED`  out  1  sticky flag: any fault since reset.
- `FAULT_ADDRESS`  out  32  `REQ_ADDRESS` of the first fault since reset.
- `DMEM_ADDRESS`  out  32  word index, equal to `REQ_ADDRESS >> 2`.
- `DMEM_WRITE_DATA`  out  32  word to write.
- `DMEM_MemRead`  out  1  read strobe to `DATA_MEMORY`.
- `DMEM_MemWrite`  out  1  write strobe to `DATA_MEMORY`.
- `DMEM_READ_DATA`  in  32  combinational read word from `DATA_MEMORY`.
- `DMEM_SEGMENTATION_FAULT`  in  1  out-of-range indication from `DATA_MEMORY`.

## Operation
- `DATA_MEMORY` contract: `READ_DATA` is combinational from `ADDRESS`; the write commits at the rising edge with `MemWrite`=1.
- Lane selection: `lane` = `REQ_ADDRESS[1:0]`.
  - Byte accesses use bits [8·lane+7 : 8·lane].
  - Halfword accesses use bits [16·lane[1]+15 : 16·lane[1]].
- Alignment rules:
  - Halfword with `lane[0]`=1 is misaligned.
  - Word with `lane`≠0 is misaligned.
- Illegal funct3:
  - For loads: 011, 110, 111.
  - For stores: any value other than 000/001/010.
- A misaligned or illegal request produces:
  - no DMEM strobe;
  - `ACCESS_FAULT`=1, `STALL`=0;
  - `LOAD_DATA`=0.
- If `REQ_MemRead` and `REQ_MemWrite` are both 1, the request is treated as a store.
- Loads (single cycle):
  - Drive `DMEM_MemRead`=1.
  - Extract the lane; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
- SW (single cycle): drive `DMEM_MemWrite`=1 with `DMEM_WRITE_DATA`=`REQ_WRITE_DATA`.
- SB/SH use the FSM with states IDLE and RMW_WRITE:
  - **IDLE:** drive `DMEM_MemRead`=1 and assert `STALL`=1. Register `merge` = `DMEM_READ_DATA` with the target lane replaced by `REQ_WRITE_DATA[7:0]` (SB) or `REQ_WRITE_DATA[15:0]` (SH). Go to RMW_WRITE.
  - **RMW_WRITE:** drive `DMEM_MemWrite`=1 and `DMEM_WRITE_DATA`=`merge`, with `STALL`=0. Return to IDLE unconditionally.
- `DMEM_SEGMENTATION_FAULT`=1 on any issued access:
  - sets `ACCESS_FAULT`=1;
  - forces `LOAD_DATA`=0;
  - in IDLE during an SB/SH read, aborts the RMW: stay in IDLE, `STALL`=0, no write issued.
- Fault latch: on the first cycle with `ACCESS_FAULT`=1 while `FAULT_LATCHED`=0:
  - set `FAULT_LATCHED`;
  - capture `REQ_ADDRESS` into `FAULT_ADDRESS`;
  - later faults do not overwrite it.
- With no request (both REQ strobes 0), all DMEM strobes are 0 and `STALL`=0.

## Timing
- Reset state: FSM=IDLE, `merge`=0, `FAULT_LATCHED`=0, `FAULT_ADDRESS`=0.
- Outputs with no request after reset: `STALL`=0, DMEM strobes=0, `ACCESS_FAULT`=0, `LOAD_DATA`=0.
- Latency per request type:
  - Loads and SW: 0 extra cycles; `STALL` is never asserted.
  - SB/SH: exactly 2 cycles (read cycle with `STALL`=1, then write cycle with `STALL`=0). The memory word updates at the edge ending the second cycle.
- The pipeline advances at the edge ending RMW_WRITE, so the next request is seen in IDLE.
- Back-to-back SB/SH requests each take 2 cycles; there are no bubbles between them.
- `RST` asserted in RMW_WRITE: the write strobe still shows combinationally in that cycle, but the state returns to IDLE and the pipeline is reset with it. Verification checks only the state after reset.
- The fault latch updates at the rising edge; `FAULT_ADDRESS` is visible in the following cycle.

## Test plan
- **Word store then byte loads:** SW 0xDEADBEEF @0x10; then LB/LBU @0x13.
  - Expected: LB gives 0xFFFFFFDE, LBU gives 0x000000DE.
  - Expected: `STALL` never asserted.
- **SB read-modify-write:** SB 0x55 @0x11 over word 0x11223344 @0x10.
  - Expected: `STALL`=1 for one cycle, then DMEM write of 0x11225544.
  - Expected: subsequent LW @0x10 = 0x11225544.
- **SH with sign extension:** SH 0x8001 @0x22 over 0; then LH @0x22 and LHU @0x22.
  - Expected: LH gives 0xFFFF8001, LHU gives 0x00008001.
- **Misaligned accesses:** LW @0x06; then SH @0x03.
  - Expected for both: `ACCESS_FAULT`=1, no DMEM strobe, `STALL`=0.
  - Expected: `FAULT_LATCHED`=1, `FAULT_ADDRESS`=0x06 (second fault does not overwrite).
- **Segmentation fault mid-RMW:** SB to a word index beyond memory with `DMEM_SEGMENTATION_FAULT`=1.
  - Expected: no write, FSM stays IDLE, `STALL`=0, `ACCESS_FAULT`=1.
- **Reset:** assert `RST` during RMW_WRITE.
  - Expected next cycle: FSM=IDLE, `STALL`=0, `FAULT_LATCHED`=0, `FAULT_ADDRESS`=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Purpose: RV32I byte-addressed loads/stores onto word-indexed DATA_MEMORY, with extension, fault detection and a sticky first-fault latch.
// Latency: loads and SW take 1 cycle; SB/SH take 2 cycles (read + merge, then write).
// Backpressure: STALL is high only in the SB/SH read cycle; the pipeline holds REQ_* stable while it is high.
module load_store_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] REQ_ADDRESS,
    input  logic [2:0]  REQ_FUNCT3,
    input  logic        REQ_MemRead,
    input  logic        REQ_MemWrite,
    input  logic [31:0] REQ_WRITE_DATA,
    output logic        STALL,
    output logic [31:0] LOAD_DATA,
    output logic        ACCESS_FAULT,
    output logic        FAULT_LATCHED,
    output logic [31:0] FAULT_ADDRESS,
    output logic [31:0] DMEM_ADDRESS,
    output logic [31:0] DMEM_WRITE_DATA,
    output logic        DMEM_MemRead,
    output logic        DMEM_MemWrite,
    input  logic [31:0] DMEM_READ_DATA,
    input  logic        DMEM_SEGMENTATION_FAULT
);

    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t      state, next_state;
    logic [31:0] merge, merge_nxt;

    logic [1:0]  lane;
    logic        is_store, is_load;
    logic        misaligned, illegal, bad_req;
    logic [4:0]  byte_sh, half_sh;
    logic [31:0] byte_shifted, half_shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] ext_data, merged;

    assign lane         = REQ_ADDRESS[1:0];
    // A simultaneous read+write request is treated as a store.
    assign is_store     = REQ_MemWrite;
    assign is_load      = REQ_MemRead & ~REQ_MemWrite;
    assign DMEM_ADDRESS = {2'b00, REQ_ADDRESS[31:2]};

    always_comb begin
        misaligned = 1'b0;
        case (REQ_FUNCT3[1:0])
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (is_store)
            illegal = (REQ_FUNCT3 != 3'b000) && (REQ_FUNCT3 != 3'b001) && (REQ_FUNCT3 != 3'b010);
        else if (is_load)
            illegal = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3 == 3'b110) || (REQ_FUNCT3 == 3'b111);
    end

    assign bad_req = (is_store | is_load) & (misaligned | illegal);

    assign byte_sh      = {lane, 3'b000};
    assign half_sh      = {lane[1], 4'b0000};
    assign byte_shifted = DMEM_READ_DATA >> byte_sh;
    assign half_shifted = DMEM_READ_DATA >> half_sh;
    assign byte_val     = byte_shifted[7:0];
    assign half_val     = half_shifted[15:0];

    always_comb begin
        ext_data = 32'h0;
        case (REQ_FUNCT3)
            3'b000:  ext_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  ext_data = {{16{half_val[15]}}, half_val};
            3'b010:  ext_data = DMEM_READ_DATA;
            3'b100:  ext_data = {24'h0, byte_val};
            3'b101:  ext_data = {16'h0, half_val};
            default: ext_data = 32'h0;
        endcase
    end

    always_comb begin
        if (REQ_FUNCT3[0])
            merged = (DMEM_READ_DATA & ~(32'h0000_FFFF << half_sh))
                   | ({16'h0, REQ_WRITE_DATA[15:0]} << half_sh);
        else
            merged = (DMEM_READ_DATA & ~(32'h0000_00FF << byte_sh))
                   | ({24'h0, REQ_WRITE_DATA[7:0]} << byte_sh);
    end

    always_comb begin
        next_state      = state;
        merge_nxt       = merge;
        DMEM_MemRead    = 1'b0;
        DMEM_MemWrite   = 1'b0;
        DMEM_WRITE_DATA = 32'h0;
        STALL           = 1'b0;
        ACCESS_FAULT    = bad_req;
        LOAD_DATA       = 32'h0;
        case (state)
            IDLE: begin
                if (bad_req) begin
                    ACCESS_FAULT = 1'b1;
                end else if (is_store) begin
                    if (REQ_FUNCT3 == 3'b010) begin
                        DMEM_MemWrite   = 1'b1;
                        DMEM_WRITE_DATA = REQ_WRITE_DATA;
                        ACCESS_FAULT    = DMEM_SEGMENTATION_FAULT;
                    end else begin
                        DMEM_MemRead = 1'b1;
                        // An out-of-range read aborts the RMW before any write.
                        if (DMEM_SEGMENTATION_FAULT) begin
                            ACCESS_FAULT = 1'b1;
                        end else begin
                            STALL      = 1'b1;
                            merge_nxt  = merged;
                            next_state = RMW_WRITE;
                        end
                    end
                end else if (is_load) begin
                    DMEM_MemRead = 1'b1;
                    if (DMEM_SEGMENTATION_FAULT)
                        ACCESS_FAULT = 1'b1;
                    else
                        LOAD_DATA = ext_data;
                end
            end
            RMW_WRITE: begin
                DMEM_MemWrite   = 1'b1;
                DMEM_WRITE_DATA = merge;
                ACCESS_FAULT    = bad_req | DMEM_SEGMENTATION_FAULT;
                next_state      = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            merge         <= 32'h0;
            FAULT_LATCHED <= 1'b0;
            FAULT_ADDRESS <= 32'h0;
        end else begin
            state <= next_state;
            merge <= merge_nxt;
            if (ACCESS_FAULT && !FAULT_LATCHED) begin
                FAULT_LATCHED <= 1'b1;
                FAULT_ADDRESS <= REQ_ADDRESS;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 16-word behavioural DATA_MEMORY.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] REQ_ADDRESS;
    logic [2:0]  REQ_FUNCT3;
    logic        REQ_MemRead;
    logic        REQ_MemWrite;
    logic [31:0] REQ_WRITE_DATA;
    logic        STALL;
    logic [31:0] LOAD_DATA;
    logic        ACCESS_FAULT;
    logic        FAULT_LATCHED;
    logic [31:0] FAULT_ADDRESS;
    logic [31:0] DMEM_ADDRESS;
    logic [31:0] DMEM_WRITE_DATA;
    logic        DMEM_MemRead;
    logic        DMEM_MemWrite;
    logic [31:0] DMEM_READ_DATA;
    logic        DMEM_SEGMENTATION_FAULT;

    logic [31:0] mem [16];
    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    load_store_unit dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .REQ_ADDRESS             (REQ_ADDRESS),
        .REQ_FUNCT3              (REQ_FUNCT3),
        .REQ_MemRead             (REQ_MemRead),
        .REQ_MemWrite            (REQ_MemWrite),
        .REQ_WRITE_DATA          (REQ_WRITE_DATA),
        .STALL                   (STALL),
        .LOAD_DATA               (LOAD_DATA),
        .ACCESS_FAULT            (ACCESS_FAULT),
        .FAULT_LATCHED           (FAULT_LATCHED),
        .FAULT_ADDRESS           (FAULT_ADDRESS),
        .DMEM_ADDRESS            (DMEM_ADDRESS),
        .DMEM_WRITE_DATA         (DMEM_WRITE_DATA),
        .DMEM_MemRead            (DMEM_MemRead),
        .DMEM_MemWrite           (DMEM_MemWrite),
        .DMEM_READ_DATA          (DMEM_READ_DATA),
        .DMEM_SEGMENTATION_FAULT (DMEM_SEGMENTATION_FAULT)
    );

    // Memory model: combinational read, write at the rising edge, 16 words in range.
    assign DMEM_READ_DATA = (DMEM_ADDRESS < 32'd16) ? mem[DMEM_ADDRESS[3:0]] : 32'h0;
    assign DMEM_SEGMENTATION_FAULT = (DMEM_ADDRESS >= 32'd16) && (DMEM_MemRead || DMEM_MemWrite);

    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (DMEM_MemWrite && DMEM_ADDRESS < 32'd16) begin
            mem[DMEM_ADDRESS[3:0]] <= DMEM_WRITE_DATA;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // Apply a request just after the edge, then sample at the falling edge.
    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        REQ_MemRead    = mr;
        REQ_MemWrite   = mw;
        REQ_FUNCT3     = f3;
        REQ_ADDRESS    = addr;
        REQ_WRITE_DATA = wd;
        @(negedge CLK);
    endtask

    task automatic hold_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        RST = 1'b1;
        REQ_ADDRESS = 32'h0; REQ_FUNCT3 = 3'b000;
        REQ_MemRead = 1'b0;  REQ_MemWrite = 1'b0; REQ_WRITE_DATA = 32'h0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);

        // Reset state with no request
        chk("rst_stall",  {31'h0, STALL},         32'h0);
        chk("rst_rd",     {31'h0, DMEM_MemRead},  32'h0);
        chk("rst_wr",     {31'h0, DMEM_MemWrite}, 32'h0);
        chk("rst_fault",  {31'h0, ACCESS_FAULT},  32'h0);
        chk("rst_load",   LOAD_DATA,              32'h0);
        chk("rst_latch",  {31'h0, FAULT_LATCHED}, 32'h0);
        chk("rst_faddr",  FAULT_ADDRESS,          32'h0);

        // SW then sign/zero-extended byte loads; read+write together counts as a store
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_stall", {31'h0, STALL},         32'h0);
        chk("sw_wr",    {31'h0, DMEM_MemWrite}, 32'h1);
        chk("sw_rd",    {31'h0, DMEM_MemRead},  32'h0);
        chk("sw_addr",  DMEM_ADDRESS,           32'h4);
        chk("sw_data",  DMEM_WRITE_DATA,        32'hDEADBEEF);
        drive(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_rd",    {31'h0, DMEM_MemRead},  32'h1);
        chk("lb_data",  LOAD_DATA,              32'hFFFFFFDE);
        chk("lb_stall", {31'h0, STALL},         32'h0);
        drive(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_data", LOAD_DATA,              32'h000000DE);

        // SB read-modify-write
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344);
        drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055);
        chk("sb_c1_stall", {31'h0, STALL},         32'h1);
        chk("sb_c1_rd",    {31'h0, DMEM_MemRead},  32'h1);
        chk("sb_c1_wr",    {31'h0, DMEM_MemWrite}, 32'h0);
        hold_cycle();
        chk("sb_c2_stall", {31'h0, STALL},         32'h0);
        chk("sb_c2_wr",    {31'h0, DMEM_MemWrite}, 32'h1);
        chk("sb_c2_data",  DMEM_WRITE_DATA,        32'h11225544);
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_after_sb", LOAD_DATA,              32'h11225544);

        // SH into upper half of a zero word, then LH/LHU
        drive(1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001);
        chk("sh_c1_stall", {31'h0, STALL},         32'h1);
        hold_cycle();
        chk("sh_c2_data",  DMEM_WRITE_DATA,        32'h80010000);
        drive(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
        chk("lh_data",     LOAD_DATA,              32'hFFFF8001);
        drive(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
        chk("lhu_data",    LOAD_DATA,              32'h00008001);

        // Misaligned LW, then misaligned SH; first fault address sticks
        drive(1'b1, 1'b0, 3'b010, 32'h06, 32'h0);
        chk("mis_lw_fault", {31'h0, ACCESS_FAULT},  32'h1);
        chk("mis_lw_rd",    {31'h0, DMEM_MemRead},  32'h0);
        chk("mis_lw_wr",    {31'h0, DMEM_MemWrite}, 32'h0);
        chk("mis_lw_stall", {31'h0, STALL},         32'h0);
        chk("mis_lw_load",  LOAD_DATA,              32'h0);
        drive(1'b0, 1'b1, 3'b001, 32'h03, 32'h1234);
        chk("mis_sh_fault", {31'h0, ACCESS_FAULT},  32'h1);
        chk("mis_sh_rd",    {31'h0, DMEM_MemRead},  32'h0);
        chk("mis_sh_wr",    {31'h0, DMEM_MemWrite}, 32'h0);
        chk("mis_sh_stall", {31'h0, STALL},         32'h0);
        chk("latch_set",    {31'h0, FAULT_LATCHED}, 32'h1);
        drive(1'b1, 1'b0, 3'b011, 32'h00, 32'h0);
        chk("ill_ld_fault", {31'h0, ACCESS_FAULT},  32'h1);
        chk("ill_ld_rd",    {31'h0, DMEM_MemRead},  32'h0);
        idle();
        chk("faddr_first",  FAULT_ADDRESS,          32'h6);
        chk("idle_fault",   {31'h0, ACCESS_FAULT},  32'h0);

        // Segmentation fault aborts SB before the write
        drive(1'b0, 1'b1, 3'b000, 32'h100, 32'hAA);
        chk("seg_fault", {31'h0, ACCESS_FAULT},  32'h1);
        chk("seg_stall", {31'h0, STALL},         32'h0);
        chk("seg_wr",    {31'h0, DMEM_MemWrite}, 32'h0);
        idle();
        chk("seg_idle_wr", {31'h0, DMEM_MemWrite}, 32'h0);
        drive(1'b0, 1'b1, 3'b000, 32'h11, 32'h66);
        chk("seg_next_stall", {31'h0, STALL},    32'h1);
        hold_cycle();
        chk("seg_next_data", DMEM_WRITE_DATA,    32'h11226644);

        // Reset asserted during RMW_WRITE
        drive(1'b0, 1'b1, 3'b000, 32'h12, 32'h77);
        chk("rr_c1_stall", {31'h0, STALL}, 32'h1);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        chk("rr_c2_wr", {31'h0, DMEM_MemWrite}, 32'h1);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        REQ_MemRead = 1'b0; REQ_MemWrite = 1'b0;
        REQ_ADDRESS = 32'h0; REQ_FUNCT3 = 3'b000; REQ_WRITE_DATA = 32'h0;
        @(negedge CLK);
        chk("rr_stall", {31'h0, STALL},         32'h0);
        chk("rr_wr",    {31'h0, DMEM_MemWrite}, 32'h0);
        chk("rr_latch", {31'h0, FAULT_LATCHED}, 32'h0);
        chk("rr_faddr", FAULT_ADDRESS,          32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
